// File: rtl/uart_rx.sv
// Oversampling UART receiver: 2-flop synchronized input, start-bit validation at mid-bit,
// LSB-first data capture and a registered result with frame-error and overrun flags.
module uart_rx #(
  parameter int unsigned DW  = 8,
  parameter int unsigned OVS = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          tick,
  input  logic          rx,
  input  logic          rd,
  output logic [DW-1:0] rx_data,
  output logic          rx_valid,
  output logic          frame_err,
  output logic          overrun,
  output logic          busy
);

  localparam int unsigned SW = (OVS > 1) ? $clog2(OVS) : 1;
  localparam int unsigned BW = (DW > 1) ? $clog2(DW) : 1;

  localparam logic [SW-1:0] SMID  = SW'(OVS / 2 - 1);
  localparam logic [SW-1:0] SLAST = SW'(OVS - 1);
  localparam logic [BW-1:0] BLAST = BW'(DW - 1);

  typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

  state_e        state_q, state_d;
  logic [SW-1:0] scnt_q, scnt_d;
  logic [BW-1:0] bcnt_q, bcnt_d;
  logic [DW-1:0] shift_q, shift_d;
  logic [DW:0]   shift_ext;
  logic [DW-1:0] data_q, data_d;
  logic          valid_q, valid_d;
  logic          ferr_q, ferr_d;
  logic          ovr_q, ovr_d;
  logic          rx_meta_q, rxs;
  logic          done;

  // Both stages reset high so a reset never looks like a start edge.
  always_ff @(posedge clk) begin
    if (!rst) begin
      rx_meta_q <= 1'b1;
      rxs       <= 1'b1;
    end else begin
      rx_meta_q <= rx;
      rxs       <= rx_meta_q;
    end
  end

  assign shift_ext = {rxs, shift_q};

  always_comb begin
    state_d = state_q;
    scnt_d  = scnt_q;
    bcnt_d  = bcnt_q;
    shift_d = shift_q;
    done    = 1'b0;
    if (tick) begin
      unique case (state_q)
        StIdle: begin
          if (!rxs) begin
            state_d = StStart;
            scnt_d  = '0;
            bcnt_d  = '0;
          end
        end
        StStart: begin
          if (scnt_q == SMID) begin
            // Line back high at mid-start: treat as a glitch and drop it.
            state_d = rxs ? StIdle : StData;
            scnt_d  = '0;
            bcnt_d  = '0;
          end else begin
            scnt_d = scnt_q + 1'b1;
          end
        end
        StData: begin
          if (scnt_q == SLAST) begin
            shift_d = shift_ext[DW:1];
            scnt_d  = '0;
            if (bcnt_q == BLAST) begin
              state_d = StStop;
              bcnt_d  = '0;
            end else begin
              bcnt_d = bcnt_q + 1'b1;
            end
          end else begin
            scnt_d = scnt_q + 1'b1;
          end
        end
        StStop: begin
          if (scnt_q == SLAST) begin
            // Leave at mid-stop so a back-to-back start edge is not missed.
            done    = 1'b1;
            state_d = StIdle;
            scnt_d  = '0;
            bcnt_d  = '0;
          end else begin
            scnt_d = scnt_q + 1'b1;
          end
        end
        default: begin
          state_d = StIdle;
          scnt_d  = '0;
          bcnt_d  = '0;
        end
      endcase
    end
  end

  // A completing word always wins over a same-cycle acknowledge.
  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    ferr_d  = ferr_q;
    ovr_d   = ovr_q;
    if (done) begin
      data_d  = shift_q;
      valid_d = 1'b1;
      ferr_d  = ~rxs;
      ovr_d   = ~rd & (valid_q | ovr_q);
    end else if (rd) begin
      valid_d = 1'b0;
      ovr_d   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= StIdle;
      scnt_q  <= '0;
      bcnt_q  <= '0;
      shift_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      scnt_q  <= scnt_d;
      bcnt_q  <= bcnt_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
      ovr_q   <= ovr_d;
    end
  end

  assign rx_data   = data_q;
  assign rx_valid  = valid_q;
  assign frame_err = ferr_q;
  assign overrun   = ovr_q;
  assign busy      = (state_q != StIdle);

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: a tick-timeline reference model checked every cycle, directed frames
// with literal expectations, then randomized frames, glitches, acknowledges and resets.
module tb_uart_rx;

  localparam int DW       = 8;
  localparam int OVS      = 16;
  localparam int BIT_CLK  = OVS * 4;
  localparam int DONE_AGE = OVS / 2 + OVS * (DW + 1);

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          tick = 1'b0;
  logic          rx = 1'b1;
  logic          rd = 1'b0;
  logic [DW-1:0] rx_data;
  logic          rx_valid;
  logic          frame_err;
  logic          overrun;
  logic          busy;

  uart_rx #(
    .DW (DW),
    .OVS(OVS)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .tick     (tick),
    .rx       (rx),
    .rd       (rd),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .frame_err(frame_err),
    .overrun  (overrun),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  bit chk_en = 1'b0;
  bit tick_rand = 1'b0;
  bit rd_rand = 1'b0;
  bit rd_on_done = 1'b0;
  bit rd_req = 1'b0;

  // Reference: the receiver is a timeline measured in ticks from the detected start edge.
  logic [1:0]    m_hist = 2'b11;
  bit            m_recv = 1'b0;
  int            m_age = 0;
  logic [DW-1:0] m_word = '0;
  logic [DW-1:0] e_data = '0;
  logic          e_valid = 1'b0;
  logic          e_ferr = 1'b0;
  logic          e_ovr = 1'b0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, got, exp);
    end
  endtask

  always @(posedge clk) begin : model
    logic rxs_m;
    bit   fin;
    int   off;
    rxs_m = m_hist[1];
    fin   = 1'b0;
    if (!rst) begin
      m_hist  = 2'b11;
      m_recv  = 1'b0;
      m_age   = 0;
      e_data  = '0;
      e_valid = 1'b0;
      e_ferr  = 1'b0;
      e_ovr   = 1'b0;
    end else begin
      m_hist = {m_hist[0], rx};
      if (tick) begin
        if (!m_recv) begin
          if (!rxs_m) begin
            m_recv = 1'b1;
            m_age  = 0;
          end
        end else begin
          m_age++;
          off = m_age - OVS / 2;
          if (off == 0 && rxs_m) m_recv = 1'b0;
          else if (off > 0 && off <= OVS * DW && off % OVS == 0) m_word[off / OVS - 1] = rxs_m;
          else if (m_age == DONE_AGE) begin
            fin    = 1'b1;
            m_recv = 1'b0;
          end
        end
      end
      if (fin) begin
        e_data  = m_word;
        e_ferr  = ~rxs_m;
        e_ovr   = ~rd & (e_valid | e_ovr);
        e_valid = 1'b1;
      end else if (rd) begin
        e_valid = 1'b0;
        e_ovr   = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("rx_data", 32'(rx_data), 32'(e_data));
      check("rx_valid", 32'(rx_valid), 32'(e_valid));
      check("frame_err", 32'(frame_err), 32'(e_ferr));
      check("overrun", 32'(overrun), 32'(e_ovr));
      check("busy", 32'(busy), 32'(m_recv));
    end
  end

  // Tick and rd driver; runs just after the falling edge so it sees this edge's requests.
  initial begin : drv
    int cnt;
    cnt = 0;
    forever begin
      @(negedge clk);
      #1;
      if (tick_rand) begin
        tick = ($urandom_range(0, 3) == 0);
      end else begin
        tick = (cnt == 3);
        cnt  = (cnt + 1) % 4;
      end
      rd = rd_req || (rd_rand && $urandom_range(0, 59) == 0) ||
           (rd_on_done && tick && m_recv && m_age == DONE_AGE - 1);
    end
  end

  task automatic hold_rx(input logic v, input int clks);
    rx = v;
    repeat (clks) @(negedge clk);
  endtask

  task automatic send_frame(input logic [DW-1:0] w, input logic stop, input int stop_clks);
    hold_rx(1'b0, BIT_CLK);
    for (int i = 0; i < DW; i++) hold_rx(w[i], BIT_CLK);
    hold_rx(stop, stop_clks);
    rx = 1'b1;
  endtask

  // Drive a frame for n clocks, then reset while the line is mid-frame.
  task automatic abort_frame(input logic [DW-1:0] w, input int n);
    logic [DW+1:0] bits;
    bits = {1'b1, w, 1'b0};
    for (int c = 0; c < n; c++) begin
      rx = bits[c / BIT_CLK];
      @(negedge clk);
    end
    rst = 1'b0;
    repeat (3) @(negedge clk);
    rx  = 1'b1;
    rst = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic pulse_rd();
    rd_req = 1'b1;
    @(negedge clk);
    rd_req = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b0;
    rx  = 1'b1;
    repeat (3) @(negedge clk);
    chk_en = 1'b1;
    check("reset rx_data", 32'(rx_data), 32'h0);
    check("reset rx_valid", 32'(rx_valid), 32'h0);
    check("reset overrun", 32'(overrun), 32'h0);
    check("reset busy", 32'(busy), 32'h0);
    rst = 1'b1;
    hold_rx(1'b1, 20);

    send_frame(8'h5A, 1'b1, BIT_CLK);
    check("5A rx_data", 32'(rx_data), 32'h5A);
    check("5A rx_valid", 32'(rx_valid), 32'h1);
    check("5A frame_err", 32'(frame_err), 32'h0);
    check("5A busy", 32'(busy), 32'h0);
    pulse_rd();
    check("5A rd clears valid", 32'(rx_valid), 32'h0);

    hold_rx(1'b0, 20);
    hold_rx(1'b1, 100);
    check("false start busy", 32'(busy), 32'h0);
    check("false start valid", 32'(rx_valid), 32'h0);
    check("false start data", 32'(rx_data), 32'h5A);

    send_frame(8'hC3, 1'b0, 44);
    check("C3 rx_data", 32'(rx_data), 32'hC3);
    check("C3 rx_valid", 32'(rx_valid), 32'h1);
    check("C3 frame_err", 32'(frame_err), 32'h1);
    hold_rx(1'b1, 200);
    pulse_rd();

    send_frame(8'h11, 1'b1, BIT_CLK);
    send_frame(8'h22, 1'b1, BIT_CLK);
    check("b2b rx_data", 32'(rx_data), 32'h22);
    check("b2b overrun", 32'(overrun), 32'h1);
    check("b2b frame_err", 32'(frame_err), 32'h0);
    pulse_rd();
    check("b2b rd valid", 32'(rx_valid), 32'h0);
    check("b2b rd overrun", 32'(overrun), 32'h0);

    send_frame(8'h44, 1'b1, BIT_CLK);
    check("pre-33 valid", 32'(rx_valid), 32'h1);
    rd_on_done = 1'b1;
    send_frame(8'h33, 1'b1, BIT_CLK);
    rd_on_done = 1'b0;
    check("rd@done rx_data", 32'(rx_data), 32'h33);
    check("rd@done rx_valid", 32'(rx_valid), 32'h1);
    check("rd@done overrun", 32'(overrun), 32'h0);

    abort_frame(8'h96, 5 * BIT_CLK + BIT_CLK / 2);
    check("abort rx_data", 32'(rx_data), 32'h0);
    check("abort rx_valid", 32'(rx_valid), 32'h0);
    check("abort busy", 32'(busy), 32'h0);
    hold_rx(1'b1, 100);
    check("abort still idle", 32'(busy), 32'h0);
    send_frame(8'hA5, 1'b1, BIT_CLK);
    check("A5 rx_data", 32'(rx_data), 32'hA5);
    check("A5 rx_valid", 32'(rx_valid), 32'h1);
    check("A5 frame_err", 32'(frame_err), 32'h0);

    tick_rand = 1'b1;
    rd_rand   = 1'b1;
    for (int n = 0; n < 35; n++) begin
      int kind;
      kind = $urandom_range(0, 9);
      if (kind == 0) begin
        hold_rx(1'b0, $urandom_range(1, 30));
        hold_rx(1'b1, 100);
      end else if (kind == 1) begin
        abort_frame(DW'($urandom), $urandom_range(10, 600));
      end else if (kind < 4) begin
        send_frame(DW'($urandom), 1'b0, 44);
      end else begin
        send_frame(DW'($urandom), 1'b1, BIT_CLK);
      end
      hold_rx(1'b1, $urandom_range(0, 40));
    end
    tick_rand = 1'b0;
    rd_rand   = 1'b0;
    hold_rx(1'b1, 800);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 The block SHALL expose parameter DW, default 8, meaning data bits per frame.
REQ-002 The block SHALL expose parameter OVS, default 16, meaning sample ticks per bit period; it SHALL be even and at least 4.
REQ-003 The block SHALL have port clk  input  1  system clock.
REQ-004 The block SHALL have port rst  input  1  reset; synchronous to clk and active-low.
REQ-005 The block SHALL have port tick  input  1  single-cycle sample enable at OVS x baud, driven by the baud-rate counter's enable_out.
REQ-006 The block SHALL have port rx  input  1  asynchronous serial line; idle high.
REQ-007 The block SHALL have port rd  input  1  consumer acknowledge; clears rx_valid and overrun.
REQ-008 The block SHALL have port rx_data  output  DW  last received data word, LSB first on the line.
REQ-009 The block SHALL have port rx_valid  output  1  rx_data holds an unread word.
REQ-010 The block SHALL have port frame_err  output  1  stop bit of the last word sampled low.
REQ-011 The block SHALL have port overrun  output  1  a word completed while rx_valid was still set.
REQ-012 The block SHALL have port busy  output  1  FSM is not in IDLE.

Function
REQ-013 rx SHALL pass through a 2-flop synchronizer (both flops reset to 1) before any use; the FSM SHALL see only the synchronized value rxs.
REQ-014 The FSM SHALL have states IDLE, START, DATA and STOP; it and its counters SHALL advance only on clock edges where tick=1.
REQ-015 The sample counter SHALL be clog2(OVS) bits wide and the bit counter clog2(DW) bits wide; both SHALL clear on every state change.
REQ-016 In IDLE with tick=1 and rxs=0, the FSM SHALL move to START with the sample counter at 0.
REQ-017 In START, when the sample counter reaches OVS/2-1, the FSM SHALL go to DATA if rxs=0; if rxs=1 it SHALL return to IDLE (false start) with no output change.
REQ-018 In DATA, each time the sample counter reaches OVS-1 (one bit period after the previous sample point), rxs SHALL be shifted into the MSB of the shift register (right shift) and the bit counter SHALL increment.
REQ-019 After the DW-th data sample the FSM SHALL move to STOP.
REQ-020 In STOP, at sample counter OVS-1, the block SHALL load rx_data from the shift register, set rx_valid=1 and set frame_err=~rxs, then return to IDLE on the same edge.
REQ-021 Returning to IDLE at mid-stop SHALL allow a new start edge to be detected on the next tick (back-to-back frames).
REQ-022 rx_data, rx_valid and frame_err SHALL be registered and visible on the cycle after the completing edge.
REQ-023 When a word completes while rx_valid=1 and rd=0, overrun SHALL be set, and rx_data and frame_err SHALL be overwritten.
REQ-024 When rd=1 with no completion on the same edge, rx_valid and overrun SHALL clear; rx_data and frame_err SHALL hold.
REQ-025 When rd=1 on the same edge as a completion, the new word SHALL win: rx_valid stays 1, overrun clears, and no overrun SHALL be flagged.
REQ-026 When tick=0, all state, counters and outputs SHALL hold, except for rd-driven clears and synchronizer shifting.
REQ-027 busy SHALL be combinational, (state != IDLE).

Reset
REQ-028 When rst=0 at a clk edge: state=IDLE, all counters=0, shift register=0, rx_data=0, rx_valid=0, frame_err=0, overrun=0, synchronizer flops=1.
REQ-029 Reset asserted mid-frame SHALL abort the frame with no partial word delivered; reception SHALL restart only on a fresh start edge after rst returns high.
REQ-030 Reset SHALL take priority over tick and rd.

Verification
REQ-031 Frame 0x5A (start 0, bits 0,1,0,1,1,0,1,0, stop 1), tick every 4 clk, DW=8, OVS=16 -> rx_data=0x5A, rx_valid=1, frame_err=0; busy low after the mid-stop sample.
REQ-032 rx low for only 5 ticks, then high -> FSM returns to IDLE after the OVS/2-1 check; rx_valid stays 0 and rx_data is unchanged.
REQ-033 Frame 0xC3 with stop bit held 0 -> rx_data=0xC3, rx_valid=1, frame_err=1.
REQ-034 Two back-to-back frames 0x11 then 0x22, no rd -> after the second: rx_data=0x22, overrun=1; a following rd pulse -> rx_valid=0, overrun=0.
REQ-035 rd pulsed on exactly the completing edge of frame 0x33, with rx_valid=1 beforehand -> rx_valid=1, rx_data=0x33, overrun=0.
REQ-036 rst driven low during data bit 4 of a frame, then released, then a clean frame 0xA5 -> no output from the aborted frame; rx_data=0xA5, rx_valid=1.
